// File: rtl/rxll_frame_ctrl_if.sv
// FIFO read-port and DMA-stream signals that connect the RX frame sequencer to its neighbours.
// The master modport is the sequencer's side; the slave modport is the FIFO/DMA side.
interface rxll_frame_ctrl_if;
  logic [35:0] fifo_do;
  logic        fifo_empty;
  logic [9:0]  fifo_count;
  logic        fifo_eof_rdy;
  logic        fifo_rd_en;
  logic [31:0] dma_data;
  logic        dma_valid;
  logic        dma_ready;
  logic        dma_last;

  modport master (
    input  fifo_do, fifo_empty, fifo_count, fifo_eof_rdy, dma_ready,
    output fifo_rd_en, dma_data, dma_valid, dma_last
  );

  modport slave (
    output fifo_do, fifo_empty, fifo_count, fifo_eof_rdy, dma_ready,
    input  fifo_rd_en, dma_data, dma_valid, dma_last
  );
endinterface

// File: rtl/rxll_frame_ctrl.sv
// RX link-layer read sequencer: drains frames from the FWFT FIFO into the DMA stream and
// reports each frame's length and {nosof, overrun, err} status.
module rxll_frame_ctrl #(
  parameter int unsigned C_BURST_WORDS = 128,
  parameter int unsigned C_MAX_WORDS   = 2049
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_en,
  input  logic                 ctrl_abort,
  rxll_frame_ctrl_if.master    bus,
  output logic                 frm_done,
  output logic [15:0]          frm_len,
  output logic [2:0]           frm_status,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, XFER, FLUSH, DONE} state_t;

  localparam logic [15:0] MAX_W = 16'(C_MAX_WORDS);

  state_t      state_q;
  logic [15:0] cnt_q, cnt_inc;
  logic        err_q, ovr_q, nosof_q;
  logic        frm_done_q;
  logic [15:0] frm_len_q;
  logic [2:0]  frm_status_q;

  logic head_sof, head_eof, head_err;
  logic start_ok, accept, flush_pop;
  logic unused_rsvd;

  assign head_sof    = bus.fifo_do[35];
  assign head_eof    = bus.fifo_do[34];
  assign head_err    = bus.fifo_do[33];
  assign unused_rsvd = bus.fifo_do[32];

  always_comb begin
    start_ok = ctrl_en && !bus.fifo_empty &&
               (bus.fifo_eof_rdy ||
                ((C_BURST_WORDS != 0) && ({22'd0, bus.fifo_count} >= C_BURST_WORDS)));
    // Abort suppresses the offer immediately so no word slips out on the abort cycle.
    bus.dma_valid  = (state_q == XFER) && !bus.fifo_empty && !ctrl_abort;
    bus.dma_data   = bus.dma_valid ? bus.fifo_do[31:0] : 32'd0;
    bus.dma_last   = bus.dma_valid && head_eof;
    accept         = bus.dma_valid && bus.dma_ready;
    flush_pop      = (state_q == FLUSH) && !bus.fifo_empty;
    bus.fifo_rd_en = accept || flush_pop;
    cnt_inc        = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      ovr_q        <= 1'b0;
      nosof_q      <= 1'b0;
      frm_done_q   <= 1'b0;
      frm_len_q    <= '0;
      frm_status_q <= '0;
    end else begin
      frm_done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_ok) begin
          state_q <= head_sof ? XFER : FLUSH;
          nosof_q <= !head_sof;
        end
        XFER: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            err_q <= err_q | head_err;
            // EOF on the limit word ends the frame cleanly rather than overrunning.
            if (head_eof) begin
              frm_done_q   <= 1'b1;
              frm_len_q    <= cnt_inc;
              frm_status_q <= {nosof_q, ovr_q, err_q | head_err};
              state_q      <= DONE;
            end else if (cnt_inc >= MAX_W) begin
              ovr_q   <= 1'b1;
              state_q <= FLUSH;
            end
          end else if (ctrl_abort) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: if (flush_pop) begin
          err_q <= err_q | head_err;
          if (head_eof) begin
            frm_done_q   <= 1'b1;
            frm_len_q    <= cnt_q;
            frm_status_q <= {nosof_q, ovr_q, err_q | head_err};
            state_q      <= DONE;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          err_q   <= 1'b0;
          ovr_q   <= 1'b0;
          nosof_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frm_done   = frm_done_q;
  assign frm_len    = frm_len_q;
  assign frm_status = frm_status_q;
  assign busy       = (state_q != IDLE);
endmodule
